// File: rtl/toy_mem_arbiter.sv
// rtl/toy_mem_arbiter.sv - shares one unified memory between the RISC_TOY fetch and data ports
// Define ARB_IFETCH_HOLD_EN to add a one-entry fetch hold register that serves repeat fetches locally.
module toy_mem_arbiter #(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IREQ,
  input  logic [AW-1:0] IADDR,
  output logic [DW-1:0] INSTR,
  output logic          I_READY,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [AW-1:0] DADDR,
  input  logic [DW-1:0] DWDATA,
  output logic [DW-1:0] DRDATA,
  output logic          D_READY,
  output logic          STALL,
  output logic          ERR,
  output logic          M_REQ,
  output logic          M_RW,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic [DW-1:0] M_RDATA,
  input  logic          M_ACK
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  state_t        state;
  logic          last_d;
  logic [CW-1:0] wait_cnt;
  logic          hold_hit;
  logic [DW-1:0] hold_word;

  assign STALL = (IREQ & ~I_READY) | (DREQ & ~D_READY);

`ifdef ARB_IFETCH_HOLD_EN
  logic [AW-1:0] hold_addr;
  logic          hold_valid;

  assign hold_hit = hold_valid & ~ERR & IREQ & ~DREQ & (IADDR == hold_addr);

  // A completed data write to the held address invalidates it on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_word  <= '0;
    end else if (ERR || (state != IDLE && !M_ACK && wait_cnt == CW'(MAX_WAIT - 1))) begin
      hold_valid <= 1'b0;
    end else if (state == I_ACC && M_ACK) begin
      hold_valid <= 1'b1;
      hold_addr  <= M_ADDR;
      hold_word  <= M_RDATA;
    end else if (state == D_ACC && M_ACK && M_RW && M_ADDR == hold_addr) begin
      hold_valid <= 1'b0;
    end
  end
`else
  assign hold_hit  = 1'b0;
  assign hold_word = '0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      wait_cnt <= '0;
      INSTR    <= '0;
      DRDATA   <= '0;
      I_READY  <= 1'b0;
      D_READY  <= 1'b0;
      ERR      <= 1'b0;
      M_REQ    <= 1'b0;
      M_RW     <= 1'b0;
      M_ADDR   <= '0;
      M_WDATA  <= '0;
    end else begin
      I_READY <= 1'b0;
      D_READY <= 1'b0;
      case (state)
        IDLE: begin
          if (hold_hit) begin
            I_READY <= 1'b1;
            INSTR   <= hold_word;
          end else if (DREQ && (!IREQ || !last_d)) begin
            state   <= D_ACC;
            M_REQ   <= 1'b1;
            M_RW    <= DRW;
            M_ADDR  <= DADDR;
            M_WDATA <= DWDATA;
            last_d  <= 1'b1;
          end else if (IREQ) begin
            state  <= I_ACC;
            M_REQ  <= 1'b1;
            M_RW   <= 1'b0;
            M_ADDR <= IADDR;
            last_d <= 1'b0;
          end
        end
        default: begin
          // Either the acknowledge or the timeout ends the access; a timeout returns zero data.
          if (M_ACK || wait_cnt == CW'(MAX_WAIT - 1)) begin
            state    <= IDLE;
            M_REQ    <= 1'b0;
            wait_cnt <= '0;
            if (!M_ACK) ERR <= 1'b1;
            if (state == D_ACC) begin
              D_READY <= 1'b1;
              if (!M_ACK) DRDATA <= '0;
              else if (!M_RW) DRDATA <= M_RDATA;
            end else begin
              I_READY <= 1'b1;
              INSTR   <= M_ACK ? M_RDATA : '0;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_toy_mem_arbiter.sv
// tb/tb_toy_mem_arbiter.sv - self-checking bench for toy_mem_arbiter
module tb_toy_mem_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int MW = 15;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IREQ, DREQ, DRW, M_ACK;
  logic [AW-1:0] IADDR, DADDR;
  logic [DW-1:0] DWDATA, M_RDATA;
  logic [DW-1:0] INSTR, DRDATA, M_WDATA;
  logic          I_READY, D_READY, STALL, ERR, M_REQ, M_RW;
  logic [AW-1:0] M_ADDR;

  toy_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST(RST),
    .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR), .I_READY(I_READY),
    .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(DRDATA), .D_READY(D_READY),
    .STALL(STALL), .ERR(ERR),
    .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA), .M_ACK(M_ACK)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem     [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int mem_lat   = 0;
  bit mem_hang  = 1'b0;
  bit rand_lat  = 1'b0;
  bit force_ack = 1'b0;
  int wcnt      = 0;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {a[15:0], 16'h5A3C} ^ 32'h0F0F_0000;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Memory model: acknowledges after mem_lat cycles of M_REQ, or never when hung.
  initial begin
    M_ACK   = 1'b0;
    M_RDATA = '0;
    forever begin
      @(negedge CLK);
      M_ACK   = 1'b0;
      M_RDATA = '0;
      if (force_ack) begin
        M_ACK   = 1'b1;
        M_RDATA = 32'hBAD0_BAD0;
      end else if (M_REQ) begin
        if (wcnt == 0 && rand_lat) mem_lat = $urandom_range(0, 3);
        if (!mem_hang && wcnt == mem_lat) begin
          M_ACK = 1'b1;
          if (M_RW) mem[M_ADDR] = M_WDATA;
          else M_RDATA = mem.exists(M_ADDR) ? mem[M_ADDR] : init_word(M_ADDR);
        end
        wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic do_xact(input bit is_d, input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         output logic [DW-1:0] rd, output int cyc, output int mreq_n,
                         output logic m_rw, output logic [AW-1:0] m_addr, output logic [DW-1:0] m_wd,
                         output int stall_bad);
    bit got;
    got = 1'b0;
    rd = '0; cyc = 0; mreq_n = 0; m_rw = 1'b0; m_addr = '0; m_wd = '0; stall_bad = 0;
    if (is_d) begin
      DREQ = 1'b1; DRW = rw; DADDR = addr; DWDATA = wd;
    end else begin
      IREQ = 1'b1; IADDR = addr;
    end
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      if (M_REQ) begin
        mreq_n++; m_rw = M_RW; m_addr = M_ADDR; m_wd = M_WDATA;
      end
      if (is_d ? D_READY : I_READY) begin
        got = 1'b1;
        rd = is_d ? DRDATA : INSTR;
        if (STALL) stall_bad++;
      end else if (!STALL) begin
        stall_bad++;
      end
    end
    IREQ = 1'b0;
    DREQ = 1'b0;
  endtask

  typedef struct {
    bit            is_d;
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            lat;
    logic [DW-1:0] exp_rd;
    int            exp_cyc;
    int            exp_mreq;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [DW-1:0] rd, m_wd, d_last;
    logic [AW-1:0] m_addr, i_addr, d_addr;
    logic          m_rw;
    int            cyc, mreq_n, stall_bad, n_gr, idle;
    bit            prev, g_d, sp_i, sp_d, i_pend, d_pend, d_rw, m_last_d, grant_out, exp_d;
    bit            grant [4];
    int            gap [4];
    logic [DW-1:0] d_wd;
    logic [63:0]   act_v, exp_v;

    RST = 1'b1; IREQ = 1'b0; DREQ = 1'b0; DRW = 1'b0;
    IADDR = '0; DADDR = '0; DWDATA = '0;
    mem[30'h10] = 32'hDEADBEEF;
    tick(); tick();
    RST = 1'b0;
    tick();
    chk("reset_outputs", {INSTR, DRDATA}, 64'h0);
    chk("reset_ctrl", {I_READY, D_READY, STALL, ERR, M_REQ, M_RW, M_ADDR}, 64'h0);
    chk("reset_wdata", M_WDATA, 64'h0);

    // Contention: both ports held high must alternate D,I,D,I with one idle cycle between grants.
    mem_lat = 1;
    IREQ = 1'b1; IADDR = 30'h40;
    DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h50;
    prev = 1'b0; n_gr = 0; idle = 0;
    for (int t = 0; t < 60 && n_gr < 4; t++) begin
      tick();
      if (M_REQ && !prev) begin
        grant[n_gr] = (M_ADDR == 30'h50);
        gap[n_gr]   = idle;
        n_gr++;
      end
      if (!M_REQ) idle++; else idle = 0;
      prev = M_REQ;
    end
    for (int t = 0; t < 10 && !I_READY; t++) tick();
    IREQ = 1'b0; DREQ = 1'b0;
    chk("cont_grants", n_gr, 4);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("cont_order%0d", g), grant[g], (g % 2 == 0));
      if (g > 0) chk($sformatf("cont_gap%0d", g), gap[g], 1);
    end
    tick();
    chk("cont_instr", INSTR, init_word(30'h40));
    chk("cont_drdata", DRDATA, init_word(30'h50));

    tbl[0] = '{1'b0, 1'b0, 30'h10, 32'h0,          2, 32'hDEADBEEF,       4, 3};
    tbl[1] = '{1'b1, 1'b1, 30'h20, 32'h12345678,   0, init_word(30'h50),  2, 1};
    tbl[2] = '{1'b1, 1'b0, 30'h20, 32'h0,          1, 32'h12345678,       3, 2};
    tbl[3] = '{1'b1, 1'b1, 30'h30, 32'hCAFEF00D,   3, 32'h12345678,       5, 4};
    tbl[4] = '{1'b0, 1'b0, 30'h30, 32'h0,          0, 32'hCAFEF00D,       2, 1};
    tbl[5] = '{1'b1, 1'b0, 30'h10, 32'h0,          4, 32'hDEADBEEF,       6, 5};
    for (int i = 0; i < 6; i++) begin
      mem_lat = tbl[i].lat;
      do_xact(tbl[i].is_d, tbl[i].rw, tbl[i].addr, tbl[i].wd, rd, cyc, mreq_n, m_rw, m_addr, m_wd, stall_bad);
      chk($sformatf("t%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("t%0d_cycles", i), cyc, tbl[i].exp_cyc);
      chk($sformatf("t%0d_mreq_cycles", i), mreq_n, tbl[i].exp_mreq);
      chk($sformatf("t%0d_m_rw", i), m_rw, tbl[i].is_d & tbl[i].rw);
      chk($sformatf("t%0d_m_addr", i), m_addr, tbl[i].addr);
      if (tbl[i].rw) chk($sformatf("t%0d_m_wdata", i), m_wd, tbl[i].wd);
      chk($sformatf("t%0d_stall", i), stall_bad, 0);
      tick();
    end

    // Timeout on a hung memory, then a spurious acknowledge while idle.
    mem_hang = 1'b1;
    do_xact(1'b1, 1'b0, 30'h60, 32'h0, rd, cyc, mreq_n, m_rw, m_addr, m_wd, stall_bad);
    chk("to_mreq_cycles", mreq_n, MW);
    chk("to_cycles", cyc, MW + 1);
    chk("to_drdata", rd, 64'h0);
    chk("to_err", ERR, 1);
    mem_hang = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick(); tick();
    chk("late_ack_idle", {M_REQ, I_READY, D_READY}, 64'h0);
    chk("late_ack_data", DRDATA, 64'h0);
    chk("err_sticky", ERR, 1);

    // Reset in the middle of a data access.
    mem_hang = 1'b1;
    DREQ = 1'b1; DRW = 1'b1; DADDR = 30'h70; DWDATA = 32'h5555AAAA;
    tick(); tick(); tick();
    chk("rst_pre_mreq", M_REQ, 1);
    RST = 1'b1;
    #1;
    chk("rst_async", {M_REQ, ERR, D_READY, I_READY}, 64'h0);
    DREQ = 1'b0;
    tick();
    RST = 1'b0;
    mem_hang = 1'b0;
    tick();
    mem_lat = 1;
    do_xact(1'b0, 1'b0, 30'h10, 32'h0, rd, cyc, mreq_n, m_rw, m_addr, m_wd, stall_bad);
    chk("rst_fetch_data", rd, 32'hDEADBEEF);
    chk("rst_fetch_cycles", cyc, 3);
    chk("rst_err_clear", ERR, 0);

`ifdef ARB_IFETCH_HOLD_EN
    do_xact(1'b0, 1'b0, 30'h30, 32'h0, rd, cyc, mreq_n, m_rw, m_addr, m_wd, stall_bad);
    chk("hold_first_mreq", mreq_n, 2);
    do_xact(1'b0, 1'b0, 30'h30, 32'h0, rd, cyc, mreq_n, m_rw, m_addr, m_wd, stall_bad);
    chk("hold_hit_data", rd, 32'hCAFEF00D);
    chk("hold_hit_mreq", mreq_n, 0);
    chk("hold_hit_cycles", cyc, 1);
    mem_lat = 0;
    do_xact(1'b1, 1'b1, 30'h30, 32'h11111111, rd, cyc, mreq_n, m_rw, m_addr, m_wd, stall_bad);
    do_xact(1'b0, 1'b0, 30'h30, 32'h0, rd, cyc, mreq_n, m_rw, m_addr, m_wd, stall_bad);
    chk("hold_inval_data", rd, 32'h11111111);
    chk("hold_inval_mreq", mreq_n, 1);
    chk("hold_inval_cycles", cyc, 2);
`endif

    // Randomised traffic against a transaction-level model.
    tick();
    rand_lat = 1'b1;
    ref_mem = mem;
    i_pend = 1'b0; d_pend = 1'b0; sp_i = 1'b0; sp_d = 1'b0; prev = 1'b0;
    m_last_d = 1'b0; grant_out = 1'b0; exp_d = 1'b0; d_last = '0;
    i_addr = '0; d_addr = '0; d_rw = 1'b0; d_wd = '0;
    for (int t = 0; t < 600; t++) begin
      tick();
      chk("rnd_stall", STALL, (i_pend && !I_READY) || (d_pend && !D_READY));
      if (M_REQ && !prev) begin
        g_d = (sp_d && sp_i) ? !m_last_d : sp_d;
        if (g_d) begin
          act_v = {M_RW, M_ADDR, M_RW ? M_WDATA : 32'h0};
          exp_v = {d_rw, d_addr, d_rw ? d_wd : 32'h0};
          chk("rnd_grant_d", act_v, exp_v);
        end else begin
          chk("rnd_grant_i", {M_RW, M_ADDR}, {1'b0, i_addr});
        end
        m_last_d = g_d; grant_out = 1'b1; exp_d = g_d;
      end
      prev = M_REQ;
      if (I_READY || D_READY) begin
        if (grant_out) begin
          chk("rnd_ready_port", {I_READY, D_READY}, exp_d ? 2'b01 : 2'b10);
          grant_out = 1'b0;
        end else begin
`ifndef ARB_IFETCH_HOLD_EN
          chk("rnd_ready_unexpected", {I_READY, D_READY}, 64'h0);
`endif
        end
      end
      if (i_pend && I_READY) begin
        chk("rnd_instr", INSTR, ref_rd(i_addr));
        i_pend = 1'b0; IREQ = 1'b0;
      end else if (!i_pend && t < 540 && $urandom_range(0, 2) == 0) begin
        i_addr = 30'h100 + AW'($urandom_range(0, 7));
        IREQ = 1'b1; IADDR = i_addr; i_pend = 1'b1;
      end
      if (d_pend && D_READY) begin
        if (d_rw) begin
          ref_mem[d_addr] = d_wd;
          chk("rnd_drdata_kept", DRDATA, d_last);
        end else begin
          d_last = ref_rd(d_addr);
          chk("rnd_drdata", DRDATA, d_last);
        end
        d_pend = 1'b0; DREQ = 1'b0;
      end else if (!d_pend && t < 540 && $urandom_range(0, 2) == 0) begin
        d_addr = 30'h100 + AW'($urandom_range(0, 7));
        d_rw = $urandom_range(0, 1) == 1;
        d_wd = $urandom;
        DREQ = 1'b1; DRW = d_rw; DADDR = d_addr; DWDATA = d_wd; d_pend = 1'b1;
      end
      sp_i = IREQ;
      sp_d = DREQ;
    end
    chk("rnd_drained", {i_pend, d_pend}, 64'h0);
    chk("rnd_no_err", ERR, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/toy_mem_arbiter.md
Name: toy_mem_arbiter

Overview:
- Shares one single-port unified memory between the RISC_TOY instruction-fetch port (IREQ/IADDR/INSTR) and data port (DREQ/DRW/DADDR/DWDATA/DRDATA).
- Sits between the core and the memory model.
- Sequences each access as a request/acknowledge transaction and drives a pipeline STALL while any core request is pending.
- Data priority, with alternation when both ports are pending; a timeout guards against a hung memory.

Parameters:
AW, 30, word-address width
DW, 32, data width
MAX_WAIT, 15, max cycles M_REQ may stay high without M_ACK before abort (>=1)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  reset, asynchronous, active-high
IREQ  in  1  fetch request, held until I_READY
IADDR  in  AW  fetch word address
INSTR  out  DW  fetched word, valid when I_READY=1
I_READY  out  1  one-cycle fetch completion pulse
DREQ  in  1  data request, held until D_READY
DRW  in  1  1=write, 0=read
DADDR  in  AW  data word address
DWDATA  in  DW  write data
DRDATA  out  DW  read data, valid when D_READY=1
D_READY  out  1  one-cycle data completion pulse
STALL  out  1  pipeline hold
ERR  out  1  sticky timeout flag
M_REQ  out  1  memory request
M_RW  out  1  1=write
M_ADDR  out  AW  memory address
M_WDATA  out  DW  memory write data
M_RDATA  in  DW  memory read data, valid with M_ACK
M_ACK  in  1  memory acknowledge, one cycle

Behaviour:
- Reset values: all outputs 0, state IDLE, LAST_D=0, wait counter 0.
  - RST asserted mid-transaction drops M_REQ immediately (asynchronous) and discards the transaction; ERR clears.
- States: IDLE, D_ACC, I_ACC.
- IDLE arbitration, evaluated each edge:
  - DREQ&~IREQ -> D_ACC.
  - IREQ&~DREQ -> I_ACC.
  - Both pending -> D_ACC if LAST_D=0, else I_ACC.
- Grant latching, on the IDLE->x_ACC edge:
  - Latch M_ADDR/M_RW/M_WDATA from the granted port and set M_REQ=1.
  - The fetch grant forces M_RW=0.
  - LAST_D <= (grant==D).
- x_ACC:
  - M_REQ and the latched fields are held stable.
  - Counter increments each cycle M_REQ=1.
- On M_ACK in x_ACC:
  - Next edge: M_REQ=0, state IDLE.
  - Granted port's READY=1 for exactly that one cycle.
  - INSTR or DRDATA <= M_RDATA; DRDATA unchanged on writes.
  - Counter cleared.
- Latency: request sampled at edge N; M_REQ high from N+1; M_ACK in cycle N+1+k gives READY in cycle N+2+k.
  - Zero-wait memory (ACK same cycle as M_REQ): 2-cycle request-to-READY.
- Back-to-back requests: a request still high in the cycle after its READY is treated as a new request.
  - The arbiter is in IDLE during that cycle, so minimum issue spacing is one IDLE cycle.
- INSTR and DRDATA hold their last value between completions.
- STALL = (IREQ&~I_READY) | (DREQ&~D_READY), combinational.
- Timeout: counter reaches MAX_WAIT with no M_ACK →
  - Abort: M_REQ=0, state IDLE.
  - Granted port's READY pulses with data 0, so the core never hangs.
  - ERR <= 1, sticky until RST.
- M_ACK received while in IDLE (late/spurious) is ignored.
- Request inputs are not required to be stable outside a pending transaction.
  - Address/data changes after grant do not affect M_* because the fields are latched.
- Counter width: $clog2(MAX_WAIT+1); it never wraps, since it is cleared on ACK or abort.

Optional Feature:
- Macro ARB_IFETCH_HOLD_EN.
- Defined:
  - A one-entry fetch hold register (address, word, valid) is loaded on every fetch completion.
  - In IDLE, if IREQ targets the held address and valid=1 and DREQ=0, I_READY pulses next cycle with the held word; no M_REQ is issued.
  - Any data write to the held address clears valid in the same edge it completes.
  - RST or ERR clears valid.
- Undefined: every fetch goes to memory. Behaviour is otherwise identical.

Test Plan:
- Single fetch: IREQ=1, IADDR=0x10, memory ACKs 2 cycles after M_REQ with 0xDEADBEEF → M_REQ high 3 cycles, M_RW=0, I_READY one pulse, INSTR=0xDEADBEEF, STALL high until the READY cycle.
- Data write: DREQ=1, DRW=1, DADDR=0x20, DWDATA=0x12345678, zero-wait memory → M_RW=1, M_ADDR=0x20, M_WDATA=0x12345678, D_READY two cycles after the request.
- Contention: IREQ and DREQ held together for 4 transactions → grant order D,I,D,I, with exactly one IDLE cycle between grants.
- Timeout: memory never ACKs, MAX_WAIT=15 → M_REQ drops after 15 cycles, D_READY pulse with DRDATA=0, ERR=1 and held; a late M_ACK is ignored.
- Reset mid-op: RST asserted during D_ACC → M_REQ, READY and ERR go 0 asynchronously; after release a fresh IREQ completes normally.
- ARB_IFETCH_HOLD_EN: fetch 0x10 twice → second fetch has no M_REQ and READY comes one cycle after the request; a write to 0x10 in between forces the second fetch to memory.
